// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural order out; a frame becomes readable the cycle after its last write.
// Backpressure: in_ready drops while both banks hold unread frames; out_ready low holds the output sample stable.
module fft_reorder #(
  parameter int N     = 64,
  parameter int LOG2N = 6,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          sync_err
);

  localparam logic [LOG2N-1:0] LP_LAST = LOG2N'(N - 1);

  logic [DW-1:0]    r_mem [2][N];
  logic             r_wb;
  logic             r_rb;
  logic [LOG2N-1:0] r_wcnt;
  logic [LOG2N-1:0] r_rcnt;
  logic [1:0]       r_full;
  logic             r_sync_err;

  logic             w_acc;
  logic             w_xfer;
  logic             w_wlast;
  logic             w_rlast;
  logic [LOG2N-1:0] w_waddr;

  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  assign w_wlast   = (r_wcnt == LP_LAST);
  assign w_rlast   = (r_rcnt == LP_LAST);
  assign w_waddr   = f_bitrev(r_wcnt);

  // Both handshake outputs come from registered flags only, gated by rst.
  assign in_ready  = !r_full[r_wb] && !rst;
  assign out_valid = r_full[r_rb] && !rst;
  assign out_data  = r_mem[r_rb][r_rcnt];
  assign out_last  = out_valid && w_rlast;
  assign sync_err  = r_sync_err;

  assign w_acc     = in_valid && in_ready;
  assign w_xfer    = out_valid && out_ready;

  // Storage is never reset; the full flags alone decide what is readable.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wb][w_waddr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb       <= 1'b0;
      r_rb       <= 1'b0;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_full     <= 2'b00;
      r_sync_err <= 1'b0;
    end else begin
      if (w_acc) begin
        r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
        if (w_wlast) begin
          r_full[r_wb] <= 1'b1;
          r_wb         <= ~r_wb;
        end
        // Frames commit on count alone; a misplaced in_last only raises the flag.
        if (in_last != w_wlast) r_sync_err <= 1'b1;
      end
      if (w_xfer) begin
        r_rcnt <= w_rlast ? '0 : r_rcnt + 1'b1;
        if (w_rlast) begin
          r_full[r_rb] <= 1'b0;
          r_rb         <= ~r_rb;
        end
      end
    end
  end

  a_pingpong_banks_differ : assert property (@(posedge clk) disable iff (rst)
    (w_acc && w_wlast && w_xfer && w_rlast) |-> (r_wb != r_rb));

endmodule

// File: tb/tb_fft_reorder.sv
// Randomised and directed bench for fft_reorder (N=8 and N=64 instances) against a frame-level reorder model.
module tb_fft_reorder;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N = 8 instance
  logic        rst8, iv8, il8, ir8, ov8, ol8, ordy8, se8;
  logic [63:0] id8, od8;
  // N = 64 instance
  logic        rst64, iv64, il64, ir64, ov64, ol64, ordy64, se64;
  logic [63:0] id64, od64;

  fft_reorder #(.N(8), .LOG2N(3), .DW(64)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_data(id8), .in_last(il8), .in_ready(ir8),
    .out_valid(ov8), .out_data(od8), .out_last(ol8), .out_ready(ordy8), .sync_err(se8)
  );

  fft_reorder #(.N(64), .LOG2N(6), .DW(64)) u_dut64 (
    .clk(clk), .rst(rst64), .in_valid(iv64), .in_data(id64), .in_last(il64), .in_ready(ir64),
    .out_valid(ov64), .out_data(od64), .out_last(ol64), .out_ready(ordy64), .sync_err(se64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reverse the low 'bits' bits of v by peeling them off arithmetically.
  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  // Reference model: gather accepted samples per frame, then emit natural order.
  logic [63:0] part8[$];
  exp_t        exp8[$];
  logic [63:0] obs8[$];
  int          obscyc8[$];
  int          acc8 = 0;
  int          outs8 = 0;
  exp_t        e8;

  always @(negedge clk) begin
    if (rst8) begin
      part8.delete();
      exp8.delete();
    end else begin
      if (ov8 && ordy8) begin
        outs8++;
        obs8.push_back(od8);
        obscyc8.push_back(cyc);
        if (exp8.size() == 0) chk("out8_unexpected", 64'd1, 64'd0);
        else begin
          e8 = exp8.pop_front();
          chk("out8_data", od8, e8.d);
          chk("out8_last", 64'(ol8), 64'(e8.l));
        end
      end else if (!ov8) chk("out8_last_idle", 64'(ol8), 64'd0);
      if (iv8 && ir8) begin
        acc8++;
        part8.push_back(id8);
        if (part8.size() == 8) begin
          for (int n = 0; n < 8; n++) exp8.push_back('{part8[brev(n, 3)], n == 7});
          part8.delete();
        end
      end
    end
  end

  logic [63:0] part64[$];
  exp_t        exp64[$];
  int          outs64 = 0;
  exp_t        e64;

  always @(negedge clk) begin
    if (rst64) begin
      part64.delete();
      exp64.delete();
    end else begin
      if (ov64 && ordy64) begin
        outs64++;
        if (exp64.size() == 0) chk("out64_unexpected", 64'd1, 64'd0);
        else begin
          e64 = exp64.pop_front();
          chk("out64_data", od64, e64.d);
          chk("out64_last", 64'(ol64), 64'(e64.l));
        end
      end else if (!ov64) chk("out64_last_idle", 64'(ol64), 64'd0);
      if (iv64 && ir64) begin
        part64.push_back(id64);
        if (part64.size() == 64) begin
          for (int n = 0; n < 64; n++) exp64.push_back('{part64[brev(n, 6)], n == 63});
          part64.delete();
        end
      end
    end
  end

  // Callers are positioned just after a rising edge.
  task automatic send8(input logic [63:0] d, input logic l, output int w);
    iv8 = 1'b1; id8 = d; il8 = l; w = 0;
    @(negedge clk);
    while (!ir8) begin
      if (w == 500) begin
        chk("send8_timeout", 64'd0, 64'd1);
        break;
      end
      w++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic reset8();
    rst8 = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_low", 64'(ir8), 64'd0);
    chk("rst_out_valid_low", 64'(ov8), 64'd0);
    chk("rst_out_last_low", 64'(ol8), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(ir8), 64'd1);
    chk("post_rst_out_valid", 64'(ov8), 64'd0);
    chk("post_rst_sync_err", 64'(se8), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain8(input string tag);
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (exp8.size() == 0 && !ov8) break;
    end
    chk(tag, 64'(exp8.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [63:0] t1exp [8] = '{64'd0, 64'd4, 64'd2, 64'd6, 64'd1, 64'd5, 64'd3, 64'd7};

  initial begin
    int w, tw, base, obase, sent, guard;
    logic [63:0] d0;
    logic fire;
    logic done3;
    rst8 = 1'b1; iv8 = 1'b0; il8 = 1'b0; id8 = '0; ordy8 = 1'b0;
    rst64 = 1'b1; iv64 = 1'b0; il64 = 1'b0; id64 = '0; ordy64 = 1'b0;
    reset8();

    // Single frame, data k
    ordy8 = 1'b1;
    obs8.delete();
    for (int k = 0; k < 8; k++) begin
      send8(64'(k), k == 7, w);
      if (k == 6) begin
        @(negedge clk);
        chk("t1_no_early_valid", 64'(ov8), 64'd0);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("t1_valid_after_last", 64'(ov8), 64'd1);
    chk("t1_first_data", od8, 64'd0);
    @(posedge clk); #1;
    drain8("t1_drain");
    chk("t1_count", 64'(obs8.size()), 64'd8);
    for (int i = 0; i < 8; i++) if (i < obs8.size()) chk("t1_order", obs8[i], t1exp[i]);
    chk("t1_sync_err", 64'(se8), 64'd0);

    // Streaming: four back-to-back frames
    obs8.delete(); obscyc8.delete(); tw = 0;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 8; k++) begin
        send8({32'(f), 32'(k)}, k == 7, w);
        tw += w;
      end
    drain8("t2_drain");
    chk("t2_in_ready_never_dropped", 64'(tw), 64'd0);
    chk("t2_count", 64'(obs8.size()), 64'd32);
    if (obs8.size() == 32) begin
      chk("t2_consecutive", 64'(obscyc8[31] - obscyc8[0]), 64'd31);
      for (int i = 0; i < 32; i++) chk("t2_order", obs8[i], {32'(i / 8), 32'(brev(i % 8, 3))});
    end

    // Backpressure: three frames offered with out_ready low
    ordy8 = 1'b0; obs8.delete(); base = acc8; obase = outs8; done3 = 1'b0;
    fork
      begin
        int ww;
        for (int f = 0; f < 3; f++)
          for (int k = 0; k < 8; k++) send8(64'h300 + 64'(f * 8 + k), k == 7, ww);
        done3 = 1'b1;
      end
    join_none
    repeat (30) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_two_frames_accepted", 64'(acc8 - base), 64'd16);
    chk("t3_in_ready_low", 64'(ir8), 64'd0);
    chk("t3_out_valid_held", 64'(ov8), 64'd1);
    d0 = od8;
    repeat (5) @(negedge clk);
    chk("t3_stable_data", od8, d0);
    chk("t3_stable_last", 64'(ol8), 64'd0);
    @(posedge clk); #1;
    ordy8 = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (acc8 - base >= 17) break;
      @(posedge clk); #1;
    end
    chk("t3_frame2_after_drain", 64'((outs8 - obase) >= 8), 64'd1);
    for (int t = 0; t < 200 && !done3; t++) @(posedge clk);
    chk("t3_sender_done", 64'(done3), 64'd1);
    #1;
    drain8("t3_drain");
    chk("t3_count", 64'(obs8.size()), 64'd24);

    // Sync error: in_last on k=5
    for (int k = 0; k < 8; k++) begin
      send8(64'h400 + 64'(k), k == 5, w);
      if (k == 4 || k == 5) begin
        @(negedge clk);
        chk(k == 4 ? "t4_sync_clear" : "t4_sync_set", 64'(se8), 64'(k == 5));
        @(posedge clk); #1;
      end
    end
    drain8("t4_drain");
    chk("t4_sync_sticky", 64'(se8), 64'd1);

    // Reset mid-operation
    reset8();
    ordy8 = 1'b0;
    for (int k = 0; k < 8; k++) send8(64'h500 + 64'(k), k == 7, w);
    for (int k = 0; k < 5; k++) send8(64'h510 + 64'(k), 1'b0, w);
    obase = outs8;
    ordy8 = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (outs8 - obase == 3) break;
    end
    chk("t5_read_index", 64'(outs8 - obase), 64'd3);
    reset8();
    obs8.delete();
    for (int k = 0; k < 8; k++) send8(64'h600 + 64'(k), k == 7, w);
    drain8("t5_drain");
    chk("t5_count", 64'(obs8.size()), 64'd8);
    for (int i = 0; i < 8; i++) if (i < obs8.size()) chk("t5_order", obs8[i], 64'h600 + t1exp[i]);
    repeat (20) @(negedge clk);
    chk("t5_no_residue", 64'(ov8), 64'd0);

    // Random stalls, N = 64, 20 frames
    @(posedge clk); #1;
    rst64 = 1'b0;
    @(negedge clk);
    chk("t6_in_ready", 64'(ir64), 64'd1);
    @(posedge clk); #1;
    sent = 0; guard = 0;
    while (sent < 1280 && guard < 20000) begin
      @(negedge clk);
      fire = iv64 && ir64;
      if (fire) sent++;
      @(posedge clk); #1;
      guard++;
      ordy64 = 1'($urandom % 2);
      if (sent >= 1280) iv64 = 1'b0;
      else if (!iv64 || fire) begin
        iv64 = 1'($urandom % 2);
        id64 = {$urandom, $urandom};
        il64 = (sent % 64 == 63);
      end
    end
    iv64 = 1'b0;
    chk("t6_all_sent", 64'(sent), 64'd1280);
    for (int t = 0; t < 5000; t++) begin
      @(posedge clk); #1;
      ordy64 = 1'($urandom % 2);
      if (outs64 == 1280 && exp64.size() == 0) break;
    end
    chk("t6_out_count", 64'(outs64), 64'd1280);
    chk("t6_model_empty", 64'(exp64.size()), 64'd0);
    chk("t6_sync_err", 64'(se64), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Output reorder buffer placed directly downstream of the radix-2 DIF butterfly chain in the FFT datapath. It accepts complex samples in bit-reversed frequency order and returns each N-point frame in natural order. A two-bank ping-pong store lets one frame be written while the previous frame is read, so sustained throughput is one sample per cycle. Flow control on both sides uses valid/ready handshakes.

## Interface
- N, 64, points per frame; power of two, 8..1024
- LOG2N, 6, log2(N); counter and address width
- DW, 64, sample width; packing {imag[63:32], real[31:0]}, two's complement, same as the butterfly outputs
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_data  in  DW  input sample, bit-reversed order within a frame
- in_last  in  1  marks the last sample of an input frame
- in_ready  out  1  block can accept a sample
- out_valid  out  1  output sample valid
- out_data  out  DW  output sample, natural order
- out_last  out  1  high with the sample at natural index N-1
- out_ready  in  1  downstream accepts the sample
- sync_err  out  1  sticky in_last/count mismatch flag

## Operation
- Storage: two banks, bank0 and bank1, each N x DW registers. Each bank has a full flag.
- Write side: write-bank pointer wb and counter wcnt (LOG2N bits).
  - An accept happens when in_valid & in_ready.
  - in_ready = !full[wb] & !rst.
  - On accept, store in_data at mem[wb][bitrev(wcnt)], where bitrev reverses the LOG2N bits.
  - Then increment wcnt. When wcnt == N-1: set full[wb], toggle wb, wrap wcnt to 0.
- Read side: read-bank pointer rb and counter rcnt.
  - out_valid = full[rb].
  - out_data = mem[rb][rcnt], combinational from the register array.
  - out_last = out_valid & (rcnt == N-1).
  - A transfer happens when out_valid & out_ready. On transfer, increment rcnt. On the last transfer: clear full[rb], toggle rb, wrap rcnt to 0.
- Simultaneous events:
  - A frame completing on the write side and a frame draining on the read side in the same cycle always touch different banks. Both updates take effect.
  - If both sides touch the same bank's full flag in one cycle, the set and clear refer to different frames. This cannot happen while ping-pong ordering holds; assertions check it.
- Frame sync:
  - If in_last is accepted with wcnt != N-1, or wcnt == N-1 is accepted without in_last, set sync_err.
  - The frame is still committed on count alone; in_last never truncates or extends a frame.
  - sync_err clears only on rst.
- Backpressure:
  - When both banks are full, in_ready = 0 until the read side drains a bank.
  - out_ready low holds out_data/out_last stable with out_valid high.
- Reset (rst high at an edge):
  - wb, rb, wcnt, rcnt = 0; both full flags = 0; sync_err = 0.
  - Bank contents are not cleared.
  - Outputs while in and after reset: in_ready 0 while rst is high and 1 in the first cycle after; out_valid 0; out_last 0; out_data is don't-care (bank0 addr 0 contents).
  - Reset during a partial frame discards that frame and any full banks; no stale frame is output.

## Timing
- Write latency: the last sample of a frame is accepted at edge T; out_valid is high in the cycle after T. Natural index 0 is available then.
- Frame latency from first input to first output, with no stalls: N cycles.
- Throughput: one sample in and one sample out per cycle, sustained indefinitely with in_valid and out_ready held high.
- in_ready and out_valid depend only on registered state and rst. There is no combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Test plan
- Single frame, N=8: send in_data = k for k = 0..7, in_last on k=7, out_ready=1.
  - Outputs: 0,4,2,6,1,5,3,7.
  - out_valid rises the cycle after the 8th accept.
  - out_last coincides with value 7.
  - sync_err stays 0.
- Streaming, N=8: 4 back-to-back frames, frame f carrying {f, k}, out_ready=1.
  - Bit-reversed output per frame, frames in order.
  - in_ready never drops.
  - 32 outputs in 32 consecutive cycles after the first frame's latency.
- Backpressure, N=8: out_ready=0 while 3 frames are offered.
  - Two frames are accepted; in_ready goes 0 after accept 16.
  - Raising out_ready drains frame 0, then frame 1 is output, then frame 2 is accepted.
  - Data stays stable while stalled.
- Sync error: in_last asserted on k=5.
  - sync_err = 1 from the next cycle.
  - The frame still completes after 8 accepts; sync_err persists until rst.
- Reset mid-operation: assert rst after 5 accepts of frame 1 while frame 0 is being read at index 3.
  - out_valid = 0 and in_ready = 0 during rst.
  - After rst: counters 0, a fresh 8-sample frame outputs correctly, and no residue from the old frames appears.
- Alternating stalls: random in_valid/out_ready at 50% over 20 frames, N=64.
  - The scoreboard matches the natural-order reference exactly; no drops or duplicates.
